epc_bus_master: RTL and testbench
=================================

// Module: epc_bus_master
// PURPOSE
//   Bus initiator for the nCS/nWR/nRD/RDY peripheral bus used by uart and lcd
//   peripherals. Turns one-cycle user requests (write/read) into timed
//   strobe cycles, waits for the peripheral RDY handshake, and returns read
//   data. Sits between the soft-core/test logic and the peripheral it selects.
// PARAMETERS
//   DATA_W     8     data bus width
//   ADDR_W     4     peripheral register address width
//   SETUP_CYC  2     cycles nCS/ADDR/DATA_OUT are stable before strobe (1..65535)
//   STROBE_CYC 4     cycles nWR or nRD is held low (1..65535)
//   HOLD_CYC   2     cycles nCS held low after strobe rises (1..65535)
//   RDY_GUARD  4     cycles after HOLD before RDY is sampled (0..65535)
//   TIMEOUT    1023  max cycles waiting for RDY=1 after guard (1..65535)
// PORTS
//   clk       in   1       system clock, 50 MHz
//   nRST      in   1       asynchronous reset, active low
//   req       in   1       start transaction; sampled only in IDLE
//   we        in   1       1=write, 0=read; sampled with req
//   addr      in   ADDR_W  register address; sampled with req
//   wdata     in   DATA_W  write data; sampled with req
//   busy      out  1       high from accept through DONE
//   done      out  1       one-cycle pulse: transaction finished
//   err       out  1       one-cycle pulse with done: RDY timeout
//   rdata     out  DATA_W  read data, valid from done until next read done
//   nCS       out  1       chip select, active low
//   nWR       out  1       write strobe, active low
//   nRD       out  1       read strobe, active low
//   ADDR      out  ADDR_W  bus address
//   DATA_OUT  out  DATA_W  bus write data
//   DATA_IN   in   DATA_W  bus read data from peripheral
//   RDY       in   1       peripheral ready, high = idle/able to accept
// BEHAVIOUR
//   - Reset (nRST=0, asynchronous): state=IDLE; nCS=nWR=nRD=1; busy=done=err=0;
//     ADDR=0, DATA_OUT=0, rdata=0; counters=0. All outputs registered.
//   - FSM: IDLE -> SETUP -> STROBE -> HOLD -> WAIT_RDY -> DONE -> IDLE.
//   - IDLE: req=1 latches we/addr/wdata into ADDR/DATA_OUT, goes SETUP, busy=1.
//     req=0 stays IDLE. req while busy is ignored (not queued).
//   - SETUP: nCS=0, strobes high, SETUP_CYC cycles.
//   - STROBE: nWR=0 (we=1) or nRD=0 (we=0), nCS=0, STROBE_CYC cycles. Read:
//     DATA_IN captured into internal reg on last STROBE cycle edge.
//   - HOLD: strobe high, nCS still 0 (peripheral latches on rising nWR with nCS
//     low), HOLD_CYC cycles; ADDR/DATA_OUT unchanged through HOLD.
//   - WAIT_RDY: nCS=1. First RDY_GUARD cycles RDY ignored (peripheral RDY drop
//     lags strobe). Then RDY=1 -> DONE; else after TIMEOUT cycles -> DONE with err.
//   - DONE: one cycle, done=1, err per timeout; read: rdata updated same edge
//     done rises (also on timeout). Write: rdata unchanged. busy drops leaving DONE.
//   - Earliest next accept: cycle after DONE (req held high -> back-to-back).
//   - Phase counter 16-bit, reloads 0 on each state entry; no wrap possible
//     within parameter limits.
//   - Reset mid-transaction: bus strobes/nCS return high immediately; no done.
// TESTING
//   - Write: req,we=1,addr=3,wdata=0x41, RDY=1 -> nCS low cycles 0-7 after
//     accept, nWR low cycles 2-5, DATA_OUT=0x41, done+busy-fall at cycle 12, err=0.
//   - Read: we=0, DATA_IN=0x5A during strobe, RDY pulses low 3 cycles in guard
//     -> nRD low cycles 2-5, rdata=0x5A with done at cycle 12.
//   - RDY held low: done=1,err=1 at cycle 8+RDY_GUARD+TIMEOUT; nCS=1; then IDLE.
//   - Back-to-back: req held high for two writes 0x11,0x22 -> second accept
//     cycle after first done; no strobe overlap; req during busy ignored.
//   - nRST low during STROBE -> nCS/nWR/nRD=1 same cycle, busy=0, no done;
//     next req runs full normal sequence.
//   - Against uart peripheral: write 0x55 -> TxD frame 0x55; rx 0xA3 then read
//     -> rdata=0xA3, done after RDY returns high.

Source files
------------

// File: rtl/epc_bus_master.sv
// Initiator for the nCS/nWR/nRD/RDY peripheral bus: turns a one-cycle request into
// a timed setup/strobe/hold cycle, waits for RDY (with guard and timeout), returns read data.
module epc_bus_master #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RDY_GUARD  = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              nCS,
    output logic              nWR,
    output logic              nRD,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA_OUT,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              RDY,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [15:0] L_SETUP_LAST  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] L_STROBE_LAST = 16'(STROBE_CYC - 1);
    localparam logic [15:0] L_HOLD_LAST   = 16'(HOLD_CYC - 1);
    localparam logic [15:0] L_GUARD_LAST  = 16'(RDY_GUARD - 1);
    localparam logic [15:0] L_TIMEOUT     = 16'(TIMEOUT);
    localparam logic        L_HAS_GUARD   = (RDY_GUARD != 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_nxt;
    logic                r_guard;
    logic                w_guard_nxt;
    logic                w_sample;
    logic                w_timeout;
    logic                r_we;
    logic [DATA_W-1:0]   r_cap;

    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_guard_nxt = r_guard;
        w_sample    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (req) w_state_nxt = S_SETUP;
            end
            S_SETUP: if (r_cnt == L_SETUP_LAST) begin
                w_state_nxt = S_STROBE;
                w_cnt_nxt   = '0;
            end
            S_STROBE: if (r_cnt == L_STROBE_LAST) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end
            S_HOLD: if (r_cnt == L_HOLD_LAST) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
                w_guard_nxt = L_HAS_GUARD;
            end
            S_WAIT: begin
                // The last guard edge is also the first RDY sample; afterwards r_cnt counts samples.
                w_sample = !r_guard || (r_cnt == L_GUARD_LAST);
                if (r_guard && r_cnt == L_GUARD_LAST) begin
                    w_guard_nxt = 1'b0;
                    w_cnt_nxt   = 16'd1;
                end
                if (w_sample) begin
                    if (RDY) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else if (!r_guard && r_cnt == L_TIMEOUT) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                        w_timeout   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_guard  <= 1'b0;
            r_we     <= 1'b0;
            r_cap    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            nCS      <= 1'b1;
            nWR      <= 1'b1;
            nRD      <= 1'b1;
            ADDR     <= '0;
            DATA_OUT <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_guard <= w_guard_nxt;
            if (r_state == S_IDLE && req) begin
                r_we     <= we;
                ADDR     <= addr;
                DATA_OUT <= wdata;
            end
            if (r_state == S_STROBE && w_state_nxt == S_HOLD && !r_we) r_cap <= DATA_IN;
            // Outputs are decoded from the next state so they change on the same edge as the state.
            busy <= (w_state_nxt != S_IDLE);
            done <= (w_state_nxt == S_DONE);
            err  <= (w_state_nxt == S_DONE) && w_timeout;
            nCS  <= !(w_state_nxt == S_SETUP || w_state_nxt == S_STROBE || w_state_nxt == S_HOLD);
            nWR  <= !(w_state_nxt == S_STROBE && r_we);
            nRD  <= !(w_state_nxt == S_STROBE && !r_we);
            if (w_state_nxt == S_DONE && !r_we) rdata <= r_cap;
        end
    end

endmodule

// File: tb/tb_epc_bus_master.sv
// Self-checking bench for epc_bus_master: randomized transactions compared with a
// cycle-indexed reference timeline derived from the bus phase lengths.
module tb_epc_bus_master;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int SETUP_P = 2;
    localparam int STROBE_P = 4;
    localparam int HOLD_P = 2;
    localparam int GUARD_P = 4;
    localparam int TIMEOUT_P = 1023;
    localparam int CS_LEN = SETUP_P + STROBE_P + HOLD_P;
    localparam int FIRST_SAMPLE = CS_LEN + GUARD_P - 1;
    localparam int MAXC = 1100;

    logic clk = 1'b0;
    logic nRST, req, we, RDY;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, DATA_IN;
    logic busy, done, err, nCS, nWR, nRD;
    logic [DW-1:0] rdata, DATA_OUT;
    logic [AW-1:0] ADDR;
    logic [2:0] dbg_state;

    epc_bus_master #(
        .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(SETUP_P), .STROBE_CYC(STROBE_P),
        .HOLD_CYC(HOLD_P), .RDY_GUARD(GUARD_P), .TIMEOUT(TIMEOUT_P)
    ) dut (
        .clk(clk), .nRST(nRST), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .nCS(nCS), .nWR(nWR),
        .nRD(nRD), .ADDR(ADDR), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .RDY(RDY),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_rdata = '0;

    logic          rdy_pat [MAXC];
    logic [DW-1:0] din_pat [MAXC];
    logic [5:0]    obs_v   [MAXC];
    logic [5:0]    exp_v   [MAXC];
    logic [DW-1:0] dout_at [MAXC];
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_rdata;

    // Reference timeline: cycle c counts from the cycle after the accepting edge.
    task automatic model_txn(input logic m_we, input int len, output int d, output logic e);
        logic found;
        logic cs, st;
        found = 1'b0;
        d = FIRST_SAMPLE + TIMEOUT_P + 1;
        e = 1'b1;
        for (int k = 0; k <= TIMEOUT_P; k++) begin
            if (!found && rdy_pat[FIRST_SAMPLE + k]) begin
                found = 1'b1;
                d = FIRST_SAMPLE + k + 1;
                e = 1'b0;
            end
        end
        for (int c = 0; c < len; c++) begin
            cs = (c < CS_LEN);
            st = (c >= SETUP_P) && (c < SETUP_P + STROBE_P);
            exp_v[c] = {!cs, !(st && m_we), !(st && !m_we), (c <= d), (c == d), (c == d) && e};
        end
    endtask

    task automatic fill_pats(input logic all_rdy);
        for (int c = 0; c < MAXC; c++) begin
            rdy_pat[c] = all_rdy;
            din_pat[c] = DW'($urandom_range(0, 255));
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [AW-1:0] t_addr,
                           input logic [DW-1:0] t_wdata, input int ncyc);
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; RDY = 1'b1;
        @(posedge clk);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            obs_v[c] = {nCS, nWR, nRD, busy, done, err};
            dout_at[c] = DATA_OUT;
            if (c == 1) obs_addr = ADDR;
            obs_rdata = rdata;
            RDY = rdy_pat[c];
            DATA_IN = din_pat[c];
        end
        RDY = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; RDY = 1'b1; DATA_IN = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({nCS, nWR, nRD, busy, done, err} !== 6'b111000)
            $display("FAIL reset_ctrl got %b expected %b", {nCS, nWR, nRD, busy, done, err}, 6'b111000);
        else n_pass++;
        n_chk++;
        if ({ADDR, DATA_OUT, rdata} !== '0)
            $display("FAIL reset_data got %h/%h/%h expected 0/0/0", ADDR, DATA_OUT, rdata);
        else n_pass++;
        nRST = 1'b1;
        exp_rdata = '0;
    endtask

    task automatic test_write();
        int d; logic e; int bad;
        fill_pats(1'b1);
        model_txn(1'b1, 15, d, e);
        run_txn(1'b1, 4'd3, 8'h41, 15);
        bad = -1;
        for (int c = 0; c < 15; c++) if (bad < 0 && obs_v[c] !== exp_v[c]) bad = c;
        n_chk++;
        if (bad >= 0) $display("FAIL write_trace cyc %0d got %b expected %b", bad, obs_v[bad], exp_v[bad]);
        else n_pass++;
        n_chk++;
        if (obs_addr !== 4'd3 || dout_at[4] !== 8'h41)
            $display("FAIL write_bus got %h/%h expected 3/41", obs_addr, dout_at[4]);
        else n_pass++;
        n_chk++;
        if (d !== 12 || obs_v[12][1:0] !== 2'b10)
            $display("FAIL write_done_cyc12 got done/err %b model d %0d expected 10 at 12", obs_v[12][1:0], d);
        else n_pass++;
        n_chk++;
        if (obs_rdata !== exp_rdata) $display("FAIL write_rdata_kept got %h expected %h", obs_rdata, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_read();
        int d; logic e; int bad;
        fill_pats(1'b1);
        din_pat[SETUP_P + STROBE_P - 1] = 8'h5A;
        for (int c = CS_LEN; c < CS_LEN + 3; c++) rdy_pat[c] = 1'b0;
        model_txn(1'b0, 15, d, e);
        exp_rdata = 8'h5A;
        run_txn(1'b0, 4'd7, 8'h00, 15);
        bad = -1;
        for (int c = 0; c < 15; c++) if (bad < 0 && obs_v[c] !== exp_v[c]) bad = c;
        n_chk++;
        if (bad >= 0) $display("FAIL read_trace cyc %0d got %b expected %b", bad, obs_v[bad], exp_v[bad]);
        else n_pass++;
        n_chk++;
        if (obs_rdata !== exp_rdata) $display("FAIL read_rdata got %h expected %h", obs_rdata, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int d; logic e; int bad;
        fill_pats(1'b0);
        model_txn(1'b0, MAXC - 50, d, e);
        exp_rdata = din_pat[SETUP_P + STROBE_P - 1];
        run_txn(1'b0, 4'd1, 8'h00, d + 2);
        bad = -1;
        for (int c = 0; c < d + 2; c++) if (bad < 0 && obs_v[c] !== exp_v[c]) bad = c;
        n_chk++;
        if (bad >= 0) $display("FAIL timeout_trace cyc %0d got %b expected %b", bad, obs_v[bad], exp_v[bad]);
        else n_pass++;
        n_chk++;
        if (obs_v[CS_LEN + GUARD_P + TIMEOUT_P] !== 6'b111111)
            $display("FAIL timeout_err got %b expected 111111", obs_v[CS_LEN + GUARD_P + TIMEOUT_P]);
        else n_pass++;
        n_chk++;
        if (obs_rdata !== exp_rdata) $display("FAIL timeout_rdata got %h expected %h", obs_rdata, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d; logic e; int bad;
        logic [5:0] exp_bb [32];
        fill_pats(1'b1);
        model_txn(1'b1, 16, d, e);
        for (int c = 0; c < 32; c++) exp_bb[c] = (c < d + 2) ? exp_v[c] : exp_v[c - (d + 2)];
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h11;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) wdata = 8'h22;
            if (c == d + 2) req = 1'b0;
            obs_v[c] = {nCS, nWR, nRD, busy, done, err};
            dout_at[c] = DATA_OUT;
        end
        req = 1'b0;
        bad = -1;
        for (int c = 0; c < 30; c++) if (bad < 0 && obs_v[c] !== exp_bb[c]) bad = c;
        n_chk++;
        if (bad >= 0) $display("FAIL b2b_trace cyc %0d got %b expected %b", bad, obs_v[bad], exp_bb[bad]);
        else n_pass++;
        n_chk++;
        if (dout_at[4] !== 8'h11 || dout_at[d + 4] !== 8'h22)
            $display("FAIL b2b_data got %h/%h expected 11/22", dout_at[4], dout_at[d + 4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d; logic e; int bad; logic saw_done;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h99;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
        end
        n_chk++;
        if (nWR !== 1'b0 || nCS !== 1'b0) $display("FAIL mid_in_strobe got nCS %b nWR %b expected 0 0", nCS, nWR);
        else n_pass++;
        #1 nRST = 1'b0;
        #1;
        n_chk++;
        if ({nCS, nWR, nRD, busy} !== 4'b1110)
            $display("FAIL mid_reset_bus got %b expected 1110", {nCS, nWR, nRD, busy});
        else n_pass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        nRST = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_chk++;
        if (saw_done !== 1'b0) $display("FAIL mid_no_done got %b expected 0", saw_done);
        else n_pass++;
        exp_rdata = '0;
        fill_pats(1'b1);
        model_txn(1'b1, 15, d, e);
        run_txn(1'b1, 4'd6, 8'h3C, 15);
        bad = -1;
        for (int c = 0; c < 15; c++) if (bad < 0 && obs_v[c] !== exp_v[c]) bad = c;
        n_chk++;
        if (bad >= 0) $display("FAIL after_reset_trace cyc %0d got %b expected %b", bad, obs_v[bad], exp_v[bad]);
        else n_pass++;
    endtask

    task automatic test_random();
        int d; logic e; int bad; int st; int ln;
        logic r_we_t; logic [AW-1:0] r_addr_t; logic [DW-1:0] r_wd_t;
        for (int t = 0; t < 10; t++) begin
            fill_pats(1'b1);
            st = $urandom_range(0, 20);
            ln = $urandom_range(0, 12);
            for (int c = st; c < st + ln; c++) rdy_pat[c] = 1'b0;
            r_we_t = 1'($urandom_range(0, 1));
            r_addr_t = AW'($urandom_range(0, 15));
            r_wd_t = DW'($urandom_range(0, 255));
            model_txn(r_we_t, MAXC, d, e);
            if (!r_we_t) exp_rdata = din_pat[SETUP_P + STROBE_P - 1];
            run_txn(r_we_t, r_addr_t, r_wd_t, d + 2);
            bad = -1;
            for (int c = 0; c < d + 2; c++) if (bad < 0 && obs_v[c] !== exp_v[c]) bad = c;
            n_chk++;
            if (bad >= 0) $display("FAIL rnd%0d_trace cyc %0d got %b expected %b", t, bad, obs_v[bad], exp_v[bad]);
            else n_pass++;
            n_chk++;
            if (obs_addr !== r_addr_t || dout_at[SETUP_P + STROBE_P] !== r_wd_t)
                $display("FAIL rnd%0d_bus got %h/%h expected %h/%h", t, obs_addr, dout_at[SETUP_P + STROBE_P], r_addr_t, r_wd_t);
            else n_pass++;
            n_chk++;
            if (obs_rdata !== exp_rdata) $display("FAIL rnd%0d_rdata got %h expected %h", t, obs_rdata, exp_rdata);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
